// File: rtl/game_end_ctrl.sv
// Minesweeper game-end controller: counts safe reveals, decides win/loss and
// produces the blinking end-of-game strobes for the text overlay.
module game_end_ctrl #(
  parameter int CNT_W        = 9,
  parameter int BLINK_FRAMES = 30
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             new_game,
  input  logic [CNT_W-1:0] safe_cells,
  input  logic             reveal_valid,
  input  logic             reveal_mine,
  input  logic             vsync,
  output logic             game_active,
  output logic             lost,
  output logic             won,
  output logic             game_over,
  output logic             game_won,
  output logic [CNT_W-1:0] revealed_cnt
);

  localparam int FW = $clog2(BLINK_FRAMES + 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_LOST, S_WON} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [FW-1:0]    frame_q, frame_d;
  logic             blink_q, blink_d;
  logic             vsync_q;
  logic             tick;
  logic             rst_meta_q, rst_sync_q;
  logic             active_q, lost_q, won_q, over_q, gwon_q;

  // Assert immediately, release two clock edges later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  assign tick = vsync & ~vsync_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    frame_d  = frame_q;
    blink_d  = blink_q;
    if (new_game) begin
      cnt_d    = '0;
      target_d = safe_cells;
      frame_d  = '0;
      if (safe_cells == '0) begin
        state_d = S_WON;
        blink_d = 1'b1;
      end else begin
        state_d = S_PLAY;
        blink_d = 1'b0;
      end
    end else begin
      case (state_q)
        S_PLAY: begin
          frame_d = '0;
          blink_d = 1'b0;
          if (reveal_valid) begin
            if (reveal_mine) begin
              state_d = S_LOST;
              blink_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
              // WON at equality keeps the count from ever passing target.
              if (cnt_q + 1'b1 == target_q) begin
                state_d = S_WON;
                blink_d = 1'b1;
              end
            end
          end
        end
        S_LOST, S_WON: begin
          if (tick) begin
            if (frame_q == FRAME_LAST) begin
              frame_d = '0;
              blink_d = ~blink_q;
            end else begin
              frame_d = frame_q + 1'b1;
            end
          end
        end
        default: begin
          frame_d = '0;
          blink_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      target_q <= '0;
      frame_q  <= '0;
      blink_q  <= 1'b0;
      vsync_q  <= 1'b0;
      active_q <= 1'b0;
      lost_q   <= 1'b0;
      won_q    <= 1'b0;
      over_q   <= 1'b0;
      gwon_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      frame_q  <= frame_d;
      blink_q  <= blink_d;
      vsync_q  <= vsync;
      active_q <= (state_d == S_PLAY);
      lost_q   <= (state_d == S_LOST);
      won_q    <= (state_d == S_WON);
      over_q   <= (state_d == S_LOST) & blink_d;
      gwon_q   <= (state_d == S_WON) & blink_d;
    end
  end

  assign game_active  = active_q;
  assign lost         = lost_q;
  assign won          = won_q;
  assign game_over    = over_q;
  assign game_won     = gwon_q;
  assign revealed_cnt = cnt_q;

endmodule
